// File: rtl/div_6432.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor.
// Produces one quotient bit per clock; start/ready_n handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    1-cycle request, operands sampled on the same edge
//   ina      dividend (2W bits)
//   inb      divisor (W bits)
//   q, r     quotient / remainder (W bits each)
//   ovf      quotient does not fit in W bits (includes divide by zero)
//   dz       divide by zero
//   busy     high while iterating
//   ready_n  low when q/r/ovf/dz hold the result of the last request
module div_6432 #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] ina,
    input  logic [W-1:0]   inb,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           ovf,
    output logic           dz,
    output logic           busy,
    output logic           ready_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_alo;
    logic [W-1:0]     r_b;
    // Partial remainder stays below the divisor, so W bits suffice for
    // storage; the trial subtraction below is done on W+1 bits.
    logic [W-1:0]     r_p;
    logic [W-1:0]     r_qs;
    logic [CNT_W-1:0] r_cnt;
    // Overflow / zero-divisor result is due on the edge after start.
    logic             r_pend;

    logic [W:0]       w_t;
    logic             w_ge;
    logic [W-1:0]     w_diff;
    logic [W-1:0]     w_pn;
    logic [W-1:0]     w_qn;
    logic             w_ovf_in;
    logic             w_last;

    assign w_t      = {r_p, r_qs[W-1]};
    assign w_ge     = (w_t >= {1'b0, r_b});
    // When w_ge holds the true difference is < r_b, so it fits in W bits.
    assign w_diff   = w_t[W-1:0] - r_b;
    assign w_pn     = w_ge ? w_diff : w_t[W-1:0];
    assign w_qn     = {r_qs[W-2:0], w_ge};
    // inb == 0 is covered too: any high half is >= 0.
    assign w_ovf_in = (ina[2*W-1:W] >= inb);
    assign w_last   = (r_cnt == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_alo   <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_qs    <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            q       <= '0;
            r       <= '0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            busy    <= 1'b0;
            ready_n <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_alo   <= ina[W-1:0];
                        r_b     <= inb;
                        ready_n <= 1'b1;
                        ovf     <= 1'b0;
                        dz      <= 1'b0;
                        r_cnt   <= '0;
                        if (w_ovf_in) begin
                            r_pend  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pend  <= 1'b0;
                            busy    <= 1'b1;
                            r_p     <= ina[2*W-1:W];
                            r_qs    <= ina[W-1:0];
                            r_state <= S_CALC;
                        end
                    end else if (r_pend) begin
                        // Decision taken from the latched operands.
                        r_pend  <= 1'b0;
                        q       <= '1;
                        r       <= r_alo;
                        dz      <= (r_b == '0);
                        ovf     <= 1'b1;
                        ready_n <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_p   <= w_pn;
                    r_qs  <= w_qn;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        q       <= w_qn;
                        r       <= w_pn;
                        busy    <= 1'b0;
                        ready_n <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_6432.sv
// Self-checking bench for div_6432: behavioural model with per-cycle
// compare, literal directed cases, reset abort and random regression.
module tb_div_6432;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] ina;
    logic [31:0] inb;
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    logic        dz;
    logic        busy;
    logic        ready_n;

    int n_chk;
    int n_fail;
    bit cmp_en;

    div_6432 #(.W(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ina     (ina),
        .inb     (inb),
        .q       (q),
        .r       (r),
        .ovf     (ovf),
        .dz      (dz),
        .busy    (busy),
        .ready_n (ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: result from / and %, timing as a countdown.
    logic [31:0] m_q, m_r, m_eq, m_er;
    logic        m_ovf, m_dz, m_eovf, m_edz, m_busy, m_rdyn;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= 0; m_r <= 0; m_ovf <= 0; m_dz <= 0;
            m_busy <= 0; m_rdyn <= 1; m_wait <= 0;
            m_eq <= 0; m_er <= 0; m_eovf <= 0; m_edz <= 0;
        end else if (start && !m_busy) begin
            m_rdyn <= 1;
            m_ovf  <= 0;
            m_dz   <= 0;
            if (inb == 0 || ina[63:32] >= inb) begin
                m_wait <= 1;
                m_eq   <= 32'hFFFF_FFFF;
                m_er   <= ina[31:0];
                m_eovf <= 1;
                m_edz  <= (inb == 0);
            end else begin
                m_busy <= 1;
                m_wait <= 32;
                m_eq   <= 32'(ina / {32'd0, inb});
                m_er   <= 32'(ina % {32'd0, inb});
                m_eovf <= 0;
                m_edz  <= 0;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_q    <= m_eq;
                m_r    <= m_er;
                m_ovf  <= m_eovf;
                m_dz   <= m_edz;
                m_busy <= 0;
                m_rdyn <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_q", 64'(q), 64'(m_q));
            chk("cyc_r", 64'(r), 64'(m_r));
            chk("cyc_ovf", 64'(ovf), 64'(m_ovf));
            chk("cyc_dz", 64'(dz), 64'(m_dz));
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_ready_n", 64'(ready_n), 64'(m_rdyn));
        end
    end

    // One request; returns edges to ready_n low and busy-high cycles.
    // pulse_at > 0 re-pulses start with junk operands mid-calculation.
    task automatic run(input logic [63:0] a, input logic [31:0] b,
                       input int pulse_at, output int lat, output int bcnt);
        int k;
        start = 1; ina = a; inb = b;
        @(posedge clk); #1;
        chk("ready_n_clear", 64'(ready_n), 64'd1);
        start = 0;
        ina = {$urandom, $urandom};
        inb = $urandom;
        bcnt = int'(busy);
        k = 0;
        lat = -1;
        while (k < 40) begin
            if (pulse_at > 0 && k == pulse_at) begin
                start = 1; ina = {$urandom, $urandom}; inb = $urandom | 1;
            end else begin
                start = 0;
            end
            @(posedge clk); #1;
            k++;
            if (ready_n == 1'b0) begin
                lat = k;
                break;
            end
            bcnt += int'(busy);
        end
        start = 0;
        if (lat < 0) chk("timeout", 64'd1, 64'd0);
    endtask

    task automatic directed(input string nm, input logic [63:0] a,
                            input logic [31:0] b, input logic [31:0] eq,
                            input logic [31:0] er, input bit eo,
                            input bit ed, input int elat, input int pulse);
        int lat, bc;
        run(a, b, pulse, lat, bc);
        chk({nm, "_q"}, 64'(q), 64'(eq));
        chk({nm, "_r"}, 64'(r), 64'(er));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        chk({nm, "_dz"}, 64'(dz), 64'(ed));
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_busy_cyc"}, 64'(bc), eo ? 64'd0 : 64'd32);
    endtask

    initial begin
        int lat, bc;
        logic [63:0] a;
        logic [31:0] b;
        n_chk = 0; n_fail = 0; cmp_en = 0;
        rst_n = 0; start = 0; ina = 0; inb = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 64'(q), 0);
        chk("rst_r", 64'(r), 0);
        chk("rst_ready_n", 64'(ready_n), 1);
        chk("rst_busy", 64'(busy), 0);
        rst_n = 1;
        cmp_en = 1;
        @(posedge clk); #1;

        directed("t1", 64'd100, 32'd7, 32'd14, 32'd2, 0, 0, 32, 0);
        directed("t2a", 64'h0000_0001_0000_0000, 32'hFFFF_FFFF,
                 32'd1, 32'd1, 0, 0, 32, 0);
        directed("t2b", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'd0, 0, 0, 32, 0);
        directed("t3", 64'h1234_5678_9ABC_DEF0, 32'd0,
                 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1, 1, 1, 0);
        directed("t4", 64'h0000_0005_0000_0000, 32'd5,
                 32'hFFFF_FFFF, 32'd0, 1, 0, 1, 0);
        directed("t5", 64'd1000, 32'd33, 32'd30, 32'd10, 0, 0, 32, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_hold_q", 64'(q), 64'd30);
        directed("t5b", 64'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF,
                 0, 0, 32, 0);

        // Reset in the middle of an iteration.
        start = 1; ina = 64'd100; inb = 32'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("t6_q", 64'(q), 0);
        chk("t6_r", 64'(r), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_ready_n", 64'(ready_n), 1);
        chk("t6_ovf", 64'(ovf), 0);
        chk("t6_dz", 64'(dz), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        directed("t6post", 64'd0, 32'd1, 32'd0, 32'd0, 0, 0, 32, 0);

        for (int i = 0; i < 1500; i++) begin
            b = $urandom;
            if (b == 0) b = 1;
            if ($urandom_range(7) == 0)
                a = {b + 32'($urandom_range(3)), $urandom};
            else
                a = {$urandom % b, $urandom};
            run(a, b, 0, lat, bc);
            if (a[63:32] >= b) begin
                chk("rnd_ovf", 64'(ovf), 64'd1);
            end else begin
                chk("rnd_inv", {32'd0, q} * {32'd0, b} + {32'd0, r}, a);
                chk("rnd_rlt", 64'(r < b), 64'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
